// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus interconnect.
//   bus_state_e  : interconnect FSM states
//   MaxSlaves    : upper bound on the number of slave ports
//   bus_addr_t   : widest address the region-match helper handles
//   region_hit() : true when (addr & mask) == base
package bus_pkg;

  localparam int unsigned MaxSlaves    = 16;
  localparam int unsigned MaxAddrWidth = 64;

  typedef logic [MaxAddrWidth-1:0] bus_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERROR
  } bus_state_e;

  // Callers zero-extend their addresses into bus_addr_t, so any AddrWidth
  // up to MaxAddrWidth shares this one helper.
  function automatic logic region_hit(input bus_addr_t addr,
                                      input bus_addr_t base,
                                      input bus_addr_t mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational address decoder for bus_interconnect.
// Ports:
//   addr_i    : word address to decode
//   sel_o     : one-hot select; the lowest-index hit wins when regions overlap
//   any_hit_o : at least one slave region matches addr_i
module bus_addr_match
  import bus_pkg::*;
#(
  parameter int unsigned                    NumSlaves = 4,
  parameter int unsigned                    AddrWidth = 30,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveBase = '0,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveMask = '0
) (
  input  logic [AddrWidth-1:0] addr_i,
  output logic [NumSlaves-1:0] sel_o,
  output logic                 any_hit_o
);

  logic [NumSlaves-1:0] hit;
  logic                 found;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise paths that skip the assignment infer a latch.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      hit[i] = region_hit(bus_addr_t'(addr_i),
                          bus_addr_t'(SlaveBase[i*AddrWidth +: AddrWidth]),
                          bus_addr_t'(SlaveMask[i*AddrWidth +: AddrWidth]));
    end
  end

  // Priority pick: keep only the lowest-index hit.
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (hit[i] && !found) begin
        sel_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any_hit_o = |hit;

endmodule

// File: rtl/bus_interconnect.sv
// Memory-mapped interconnect between the CPU data port and NumSlaves
// peripherals: registered decode, per-slave ready handshake with wait
// states, and an error response for unmapped addresses.
// Optional feature macro BUS_TIMEOUT_EN: an access that waits TimeoutCycles
// cycles without the selected slave's ready ends with an error response.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   addr_i, wdata_i, wr_i,
//   addr_strobe_i, byte_en_i   : CPU request (strobe is a one-cycle pulse)
//   data_o, ready_o, err_o     : CPU response (ready_o is a one-cycle pulse)
//   s_addr_o, s_wdata_o,
//   s_byte_en_o                : registered request, shared by all slaves
//   s_sel_o, s_wr_o, s_strobe_o: per-slave select, write qualifier, start pulse
//   s_rdata_i, s_ready_i       : flattened slave read data and completions
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned                    NumSlaves     = 4,
  parameter int unsigned                    AddrWidth     = 30,
  parameter int unsigned                    DataWidth     = 32,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveBase     = '0,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveMask     = '0,
  parameter int unsigned                    TimeoutCycles = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AddrWidth-1:0]           addr_i,
  input  logic [DataWidth-1:0]           wdata_i,
  input  logic                           wr_i,
  input  logic                           addr_strobe_i,
  input  logic [DataWidth/8-1:0]         byte_en_i,
  output logic [DataWidth-1:0]           data_o,
  output logic                           ready_o,
  output logic                           err_o,
  output logic [AddrWidth-1:0]           s_addr_o,
  output logic [DataWidth-1:0]           s_wdata_o,
  output logic [DataWidth/8-1:0]         s_byte_en_o,
  output logic [NumSlaves-1:0]           s_sel_o,
  output logic [NumSlaves-1:0]           s_wr_o,
  output logic [NumSlaves-1:0]           s_strobe_o,
  input  logic [NumSlaves*DataWidth-1:0] s_rdata_i,
  input  logic [NumSlaves-1:0]           s_ready_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  bus_state_e           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic                 wr_q;
  logic [NumSlaves-1:0] sel_q;
  logic [NumSlaves-1:0] s_wr_q;
  logic [NumSlaves-1:0] strobe_q;
  logic [DataWidth-1:0] data_q;
  logic                 ready_q;
  logic                 err_q;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_q;
`endif

  logic [NumSlaves-1:0] match_sel;
  logic                 match_any;
  logic [DataWidth-1:0] sel_rdata;
  logic                 sel_ready;

  bus_addr_match #(
    .NumSlaves(NumSlaves),
    .AddrWidth(AddrWidth),
    .SlaveBase(SlaveBase),
    .SlaveMask(SlaveMask)
  ) u_addr_match (
    .addr_i   (addr_i),
    .sel_o    (match_sel),
    .any_hit_o(match_any)
  );

  // Only the selected slave's ready and read data are observed; others are
  // masked out by the one-hot select.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | s_rdata_i[i*DataWidth +: DataWidth];
    end
  end

  assign sel_ready = |(s_ready_i & sel_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      sel_q    <= '0;
      s_wr_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // Pulse outputs fall back to zero unless a state below raises them.
      strobe_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (addr_strobe_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= byte_en_i;
            wr_q    <= wr_i;
            if (match_any) begin
              sel_q    <= match_sel;
              s_wr_q   <= wr_i ? match_sel : '0;
              strobe_q <= match_sel;
              state_q  <= ACCESS;
`ifdef BUS_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end else begin
              data_q  <= '0;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ERROR;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            data_q  <= wr_q ? '0 : sel_rdata;
            ready_q <= 1'b1;
            state_q <= RESP;
`ifdef BUS_TIMEOUT_EN
          // A ready in the limit cycle is handled above and wins.
          end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
            sel_q   <= '0;
            s_wr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ERROR;
          end else begin
            cnt_q   <= cnt_q + CntWidth'(1);
`endif
          end
        end
        RESP, ERROR: begin
          sel_q   <= '0;
          s_wr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_byte_en_o = be_q;
  assign s_sel_o     = sel_q;
  assign s_wr_o      = s_wr_q;
  assign s_strobe_o  = strobe_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect. The bench plays the CPU and all
// slaves; expected slave choice, latency and response come from a
// transaction-level model of the address map and latency rules.
module tb_bus_interconnect;

  localparam int NS = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 16;
  localparam int NEVER = 1000;

  localparam logic [AW-1:0] BASE_A [NS] = '{30'h0000000, 30'h0004000, 30'h0004000, 30'h0008000};
  localparam logic [AW-1:0] MASK_A [NS] = '{30'h3FFC000, 30'h3FFFFFC, 30'h3FFFFFC, 30'h3FFFF00};
  localparam logic [NS*AW-1:0] SLAVE_BASE = {BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]};
  localparam logic [NS*AW-1:0] SLAVE_MASK = {MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]};

`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [AW-1:0]    addr_i;
  logic [DW-1:0]    wdata_i;
  logic             wr_i;
  logic             addr_strobe_i;
  logic [BW-1:0]    byte_en_i;
  logic [DW-1:0]    data_o;
  logic             ready_o;
  logic             err_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic [BW-1:0]    s_byte_en_o;
  logic [NS-1:0]    s_sel_o;
  logic [NS-1:0]    s_wr_o;
  logic [NS-1:0]    s_strobe_o;
  logic [NS*DW-1:0] s_rdata_i;
  logic [NS-1:0]    s_ready_i;

  int checks = 0;
  int errors = 0;

  bus_interconnect #(
    .NumSlaves    (NS),
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .SlaveBase    (SLAVE_BASE),
    .SlaveMask    (SLAVE_MASK),
    .TimeoutCycles(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wr_i         (wr_i),
    .addr_strobe_i(addr_strobe_i),
    .byte_en_i    (byte_en_i),
    .data_o       (data_o),
    .ready_o      (ready_o),
    .err_o        (err_o),
    .s_addr_o     (s_addr_o),
    .s_wdata_o    (s_wdata_o),
    .s_byte_en_o  (s_byte_en_o),
    .s_sel_o      (s_sel_o),
    .s_wr_o       (s_wr_o),
    .s_strobe_o   (s_strobe_o),
    .s_rdata_i    (s_rdata_i),
    .s_ready_i    (s_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Address map model: first region (lowest index) whose masked bits match.
  function automatic int model_decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASK_A[i]) == BASE_A[i]) return i;
    end
    return -1;
  endfunction

  task automatic randomize_rdata();
    for (int i = 0; i < NS; i++) s_rdata_i[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({data_o, ready_o, err_o, s_addr_o, s_wdata_o, s_byte_en_o, s_sel_o, s_wr_o, s_strobe_o} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not cleared data=%h rdy=%b err=%b addr=%h wdata=%h be=%h sel=%b wr=%b stb=%b, required all 0",
               tag, data_o, ready_o, err_o, s_addr_o, s_wdata_o, s_byte_en_o, s_sel_o, s_wr_o, s_strobe_o);
    end
  endtask

  // One CPU transaction, entered and left on a negedge. The selected slave
  // raises ready 'waits' cycles after its strobe cycle; unselected slaves
  // toggle ready randomly. Extra CPU strobes are issued while the bus is
  // busy (and, with poison, in the ready_o cycle); all must be ignored.
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input logic [BW-1:0] be, input int waits, input logic [DW-1:0] rdata,
                         input bit poison, input string tag);
    int            idx;
    logic [NS-1:0] oh;
    int            exp_n;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    int            n;
    int            got_n;
    bit            seen;
    logic          got_err;
    logic [DW-1:0] got_data;
    logic [AW-1:0] got_addr;
    logic [NS-1:0] noise;

    idx = model_decode(addr);
    oh  = '0;
    if (idx >= 0) oh[idx] = 1'b1;
    if (idx < 0) begin
      exp_n = 0; exp_err = 1'b1;
    end else if (TIMEOUT_ON && waits >= T) begin
      exp_n = T; exp_err = 1'b1;
    end else begin
      exp_n = waits + 1; exp_err = 1'b0;
    end
    exp_data = (exp_err || wr) ? '0 : rdata;

    addr_strobe_i = 1'b1;
    addr_i        = addr;
    wr_i          = wr;
    wdata_i       = wdata;
    byte_en_i     = be;
    s_ready_i     = NS'($urandom);
    randomize_rdata();

    n = 0; seen = 1'b0; got_n = -1;
    got_err = 1'b0; got_data = '0; got_addr = '0;
    while (!seen && n <= exp_n + 4) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (s_strobe_o !== oh) begin errors++; $display("FAIL %s strobe: got %b required %b", tag, s_strobe_o, oh); end
        checks++;
        if (s_wr_o !== (wr ? oh : '0)) begin errors++; $display("FAIL %s s_wr: got %b required %b", tag, s_wr_o, wr ? oh : '0); end
        checks++;
        if ({s_addr_o, s_wdata_o, s_byte_en_o} !== {addr, wdata, be}) begin
          errors++;
          $display("FAIL %s shared bus: got %h/%h/%h required %h/%h/%h", tag, s_addr_o, s_wdata_o, s_byte_en_o, addr, wdata, be);
        end
      end else begin
        checks++;
        if (s_strobe_o !== '0) begin errors++; $display("FAIL %s strobe width: got %b at cycle %0d required 0", tag, s_strobe_o, n); end
      end
      if (n < exp_n) begin
        checks++;
        if (s_sel_o !== oh) begin errors++; $display("FAIL %s sel: got %b at cycle %0d required %b", tag, s_sel_o, n, oh); end
      end
      if (ready_o === 1'b1) begin
        seen = 1'b1; got_n = n; got_err = err_o; got_data = data_o; got_addr = s_addr_o;
      end
      // Inputs for the next edge.
      if ((n < exp_n && ($urandom_range(0, 2) == 0)) || (n == exp_n && poison)) begin
        addr_strobe_i = 1'b1;
        addr_i        = AW'($urandom);
        wr_i          = 1'(($urandom));
        wdata_i       = DW'($urandom);
        byte_en_i     = BW'($urandom);
      end else begin
        addr_strobe_i = 1'b0;
      end
      noise     = NS'($urandom);
      s_ready_i = (noise & ~oh) | ((idx >= 0 && n == waits) ? oh : '0);
      randomize_rdata();
      if (idx >= 0 && n == waits) s_rdata_i[idx*DW +: DW] = rdata;
      n++;
    end

    checks++;
    if (got_n != exp_n) begin errors++; $display("FAIL %s latency: ready_o at cycle %0d required %0d", tag, got_n, exp_n); end
    checks++;
    if (got_err !== exp_err) begin errors++; $display("FAIL %s err_o: got %b required %b", tag, got_err, exp_err); end
    checks++;
    if (got_data !== exp_data) begin errors++; $display("FAIL %s data_o: got %h required %h", tag, got_data, exp_data); end
    checks++;
    if (seen && got_addr !== addr) begin errors++; $display("FAIL %s held addr: got %h required %h", tag, got_addr, addr); end

    // Cycle after the response: pulse gone, data held, nothing started.
    @(negedge clk);
    checks++;
    if ({ready_o, s_strobe_o, s_sel_o} !== '0) begin
      errors++;
      $display("FAIL %s post-resp: rdy=%b stb=%b sel=%b required all 0", tag, ready_o, s_strobe_o, s_sel_o);
    end
    checks++;
    if (data_o !== exp_data) begin errors++; $display("FAIL %s data hold: got %h required %h", tag, data_o, exp_data); end
    addr_strobe_i = 1'b0;
    s_ready_i     = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    addr_strobe_i = 1'b1;
    addr_i        = 30'h10;
    wr_i          = 1'b0;
    wdata_i       = DW'($urandom);
    byte_en_i     = '1;
    s_ready_i     = '1;
    randomize_rdata();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n         = 1'b1;
    addr_strobe_i = 1'b0;
    s_ready_i     = '0;
    @(negedge clk);
    check_all_zero("idle after reset");
  endtask

  task automatic test_directed();
    run_txn(30'h0000010, 1'b0, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0, "read slave0 zero-wait");
    run_txn(30'h0004001, 1'b1, 32'h000000A5, 4'h1, 4, 32'h12345678, 1'b0, "write slave1 4 waits");
    run_txn(30'h2000000, 1'b0, 32'h0, 4'hF, 0, 32'h0BADF00D, 1'b0, "unmapped read");
    run_txn(30'h0004000, 1'b0, 32'h0, 4'hF, 2, 32'hCAFEF00D, 1'b0, "overlap slave1 over slave2");
    run_txn(30'h0008042, 1'b0, 32'h0, 4'h3, 1, 32'h55AA33CC, 1'b0, "read slave3");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0:       a = AW'($urandom_range(0, 32'h3FFF));
        1:       a = AW'(32'h4000 + $urandom_range(0, 3));
        2:       a = AW'(32'h8000 + $urandom_range(0, 255));
        3:       a = AW'(32'h2000000 + $urandom_range(0, 255));
        default: a = AW'($urandom);
      endcase
      run_txn(a, 1'(($urandom)), DW'($urandom), BW'($urandom), $urandom_range(0, 5),
              DW'($urandom), 1'(($urandom)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_txn(30'h0000100, 1'b0, 32'h0, 4'hF, 0, 32'h11112222, 1'b1, "b2b first");
    run_txn(30'h0004002, 1'b1, 32'h33334444, 4'hC, 1, 32'h0, 1'b1, "b2b second");
    run_txn(30'h3000000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b1, "b2b unmapped");
    run_txn(30'h0000200, 1'b0, 32'h0, 4'hF, 3, 32'h99990000, 1'b1, "b2b after error");
  endtask

  task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
    run_txn(30'h0004000, 1'b0, 32'h0, 4'hF, NEVER, 32'h0, 1'b0, "timeout error");
    run_txn(30'h0000040, 1'b0, 32'h0, 4'hF, 0, 32'h76543210, 1'b0, "after timeout");
    run_txn(30'h0004001, 1'b0, 32'h0, 4'hF, T - 1, 32'hFEEDFACE, 1'b0, "ready at limit wins");
`else
    bit early;
    addr_strobe_i = 1'b1;
    addr_i        = 30'h0004000;
    wr_i          = 1'b0;
    s_ready_i     = '0;
    @(negedge clk);
    addr_strobe_i = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 100; k++) begin
      s_ready_i = NS'($urandom) & 4'b1101;
      @(negedge clk);
      if (ready_o === 1'b1) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL no-timeout wait: ready_o seen within 100 cycles, required none"); end
    checks++;
    if (s_sel_o !== 4'b0010) begin errors++; $display("FAIL no-timeout sel: got %b required 0010", s_sel_o); end
    rst_n     = 1'b0;
    s_ready_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("no-timeout recovery reset");
`endif
  endtask

  task automatic test_reset_mid();
    bit spurious;
    run_txn(30'h0000010, 1'b0, 32'h0, 4'hF, 0, 32'hA1B2C3D4, 1'b0, "pre-reset read");
    addr_strobe_i = 1'b1;
    addr_i        = 30'h0000020;
    wr_i          = 1'b1;
    wdata_i       = 32'h5A5A5A5A;
    byte_en_i     = 4'hF;
    s_ready_i     = '0;
    @(negedge clk);
    addr_strobe_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("reset mid-access");
    spurious = 1'b0;
    repeat (3) begin
      s_ready_i = '1;
      @(negedge clk);
      if (ready_o === 1'b1 || s_strobe_o !== '0) spurious = 1'b1;
    end
    s_ready_i = '0;
    checks++;
    if (spurious) begin errors++; $display("FAIL abandoned access: got ready_o or strobe after reset, required none"); end
    run_txn(30'h0000030, 1'b0, 32'h0, 4'hF, 2, 32'h0F0F0F0F, 1'b0, "fresh request after reset");
  endtask

  initial begin
    rst_n         = 1'b0;
    addr_strobe_i = 1'b0;
    addr_i        = '0;
    wr_i          = 1'b0;
    wdata_i       = '0;
    byte_en_i     = '0;
    s_ready_i     = '0;
    s_rdata_i     = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised memory-mapped interconnect between the CPU data port and NumSlaves peripherals (RAM, UART, timers, etc.).
- Generalises the fixed two-way RAM/IO address decode with:
  - a registered address decode;
  - a per-slave ready handshake, so slaves may insert wait states;
  - an error response for unmapped addresses.
- Sits between the cpu data bus and all slave devices in the top level.

Parameters:
- NumSlaves, 4, number of slave ports (1..16).
- AddrWidth, 30, word-address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.
- SlaveBase, {NumSlaves{AddrWidth'0}}, flattened per-slave base word addresses; slave i occupies bits [i*AddrWidth +: AddrWidth].
- SlaveMask, {NumSlaves{AddrWidth'0}}, flattened per-slave masks; slave i hits when (addr & mask_i) == base_i.
- TimeoutCycles, 16, maximum wait cycles for slave ready (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- addr_i  in  AddrWidth  CPU word address.
- wdata_i  in  DataWidth  CPU write data.
- wr_i  in  1  1=write, 0=read.
- addr_strobe_i  in  1  one-cycle request pulse.
- byte_en_i  in  DataWidth/8  byte lanes.
- data_o  out  DataWidth  read data, valid while ready_o=1.
- ready_o  out  1  one-cycle transaction-complete pulse.
- err_o  out  1  bus error, valid with ready_o.
- s_addr_o  out  AddrWidth  registered address, shared by all slaves.
- s_wdata_o  out  DataWidth  registered write data, shared.
- s_byte_en_o  out  DataWidth/8  registered byte enables, shared.
- s_sel_o  out  NumSlaves  one-hot select, held for the whole access.
- s_wr_o  out  NumSlaves  per-slave write qualifier (sel & wr).
- s_strobe_o  out  NumSlaves  one-cycle per-slave start pulse.
- s_rdata_i  in  NumSlaves*DataWidth  flattened slave read data.
- s_ready_i  in  NumSlaves  per-slave completion.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-transaction abandons the transaction with no ready_o.
- IDLE:
  - On addr_strobe_i=1, register addr, wdata, byte_en and wr.
  - Compute the hit vector; the lowest-index hit wins when regions overlap.
  - Any hit: set s_sel_o one-hot, go to ACCESS.
  - No hit: go to ERROR.
- ACCESS:
  - First cycle: s_strobe_o[sel]=1 for exactly one cycle; s_wr_o[sel]=wr.
  - Stay in ACCESS while s_ready_i[sel]=0.
  - On s_ready_i[sel]=1: latch s_rdata_i[sel] (reads; writes latch 0) and go to RESP.
  - s_ready_i may already be asserted in the strobe cycle, giving minimum latency.
  - s_ready_i from unselected slaves is ignored.
- RESP:
  - ready_o=1 and data_o=latched data for one cycle; err_o=0.
  - Clear s_sel_o, return to IDLE.
- ERROR: ready_o=1, err_o=1, data_o=0 for one cycle, then IDLE. No slave sees a strobe.
- Latency, strobe to ready_o:
  - Zero-wait slave: 3 cycles (decode, strobe/ready, resp).
  - Each wait cycle adds 1.
  - Unmapped address: 2 cycles.
- addr_strobe_i while not in IDLE: ignored. The CPU must hold off until ready_o.
- data_o holds its value between responses; only ready_o qualifies it.
- Back-to-back: a strobe in the same cycle as ready_o is ignored; a strobe in the next cycle is accepted.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS and is cleared on entry.
  - If TimeoutCycles cycles pass without s_ready_i[sel], go to ERROR (err_o=1, data_o=0).
  - A ready arriving in the same cycle the limit is reached wins.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package bus_pkg:
  - bus_state_e enum {IDLE, ACCESS, RESP, ERROR};
  - localparam MaxSlaves=16;
  - function region_hit(addr, base, mask).
- One sub-module, bus_addr_match (combinational):
  - computes the hit vector and a one-hot lowest-index select from addr, SlaveBase and SlaveMask;
  - also outputs an any_hit flag.
- The FSM, response registers and timeout counter stay in bus_interconnect.

Test Plan:
- Slave map: slave0 base 0x0000000 mask 0x3FFC000 (RAM); slave1 base 0x0004000 mask 0x3FFFFFC (UART).
- Read slave0 addr 0x10, slave returns 0xDEADBEEF with ready in the strobe cycle -> ready_o 3 cycles after strobe, data_o=0xDEADBEEF, err_o=0, s_strobe_o=0b0001 for one cycle.
- Write slave1 addr 0x4001, wdata 0xA5, byte_en 0x1, slave ready after 4 wait cycles -> s_wr_o=0b0010, s_wdata_o=0xA5, ready_o at cycle 7, err_o=0.
- Read addr 0x2000000 (unmapped) -> no s_strobe_o, ready_o+err_o at cycle 2, data_o=0.
- Overlap: slave2 configured identical to slave1, access 0x4000 -> only s_sel_o[1]=1.
- BUS_TIMEOUT_EN, TimeoutCycles=16, slave never readies -> err_o=1 with ready_o after the timeout, then a following access to slave0 succeeds; without the macro, still waiting after 100 cycles.
- rst_n=0 for one cycle during an ACCESS wait -> all outputs 0 next cycle, no ready_o, and a fresh request afterwards completes normally.
